can_error_frame_tx: RTL and testbench

CAN_ERROR_FRAME_TX -- requirements
Module: can_error_frame_tx

---
 rtl/can_error_frame_tx.sv | 199 +++++++++++++++++++
 tb/tb_can_error_frame_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_error_frame_tx.sv
// can_error_frame_tx
// Drives a CAN error or overload frame onto the bus: flag, wait for the bus
// to go recessive, delimiter, then intermission. Also reports flag bit
// errors, flag superposition overruns and delimiter form errors.
module can_error_frame_tx #(
    parameter int FLAG_LEN     = 6,
    parameter int DELIM_LEN    = 8,
    parameter int IMS_LEN      = 3,
    parameter int SUPERPOS_LIM = 8
) (
    input  logic clk_can,
    input  logic rst,
    input  logic bit_tick,
    input  logic can_rx,
    input  logic err_req,
    input  logic ovl_req,
    input  logic error_passive,
    input  logic bus_off,
    output logic can_tx,
    output logic busy,
    output logic frame_type,
    output logic frame_done,
    output logic flag_bit_err,
    output logic superpos_err,
    output logic delim_form_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLAG     = 3'd1;
    localparam logic [2:0] S_WAIT_REC = 3'd2;
    localparam logic [2:0] S_DELIM    = 3'd3;
    localparam logic [2:0] S_IMS      = 3'd4;

    localparam logic [3:0] FLAG_END  = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_END = 4'(DELIM_LEN);
    localparam logic [3:0] IMS_END   = 4'(IMS_LEN);
    localparam logic [3:0] SP_END    = 4'(SUPERPOS_LIM);

    logic [2:0] state, state_nx;
    logic       passive_l, passive_nx;
    logic       frame_type_nx;
    logic       prev_rx, prev_rx_nx;
    logic [3:0] flag_cnt, flag_cnt_nx, flag_inc;
    logic [3:0] eq_cnt, eq_cnt_nx, eq_inc;
    logic [3:0] dom_cnt, dom_cnt_nx, dom_inc;
    logic [3:0] delim_cnt, delim_cnt_nx, delim_inc;
    logic [3:0] ims_cnt, ims_cnt_nx, ims_inc;
    logic       done_nx, flag_err_nx, superpos_nx, delim_err_nx;

    // Saturating increments so no counter can wrap back into a legal range
    assign flag_inc  = (flag_cnt  == 4'hF) ? flag_cnt  : flag_cnt  + 4'd1;
    assign eq_inc    = (eq_cnt    == 4'hF) ? eq_cnt    : eq_cnt    + 4'd1;
    assign dom_inc   = (dom_cnt   == 4'hF) ? dom_cnt   : dom_cnt   + 4'd1;
    assign delim_inc = (delim_cnt == 4'hF) ? delim_cnt : delim_cnt + 4'd1;
    assign ims_inc   = (ims_cnt   == 4'hF) ? ims_cnt   : ims_cnt   + 4'd1;

    // Next-state and next-output decisions; bus_off overrides everything mid-frame
    always_comb begin
        state_nx      = state;
        passive_nx    = passive_l;
        frame_type_nx = frame_type;
        prev_rx_nx    = prev_rx;
        flag_cnt_nx   = flag_cnt;
        eq_cnt_nx     = eq_cnt;
        dom_cnt_nx    = dom_cnt;
        delim_cnt_nx  = delim_cnt;
        ims_cnt_nx    = ims_cnt;
        done_nx       = 1'b0;
        flag_err_nx   = 1'b0;
        superpos_nx   = 1'b0;
        delim_err_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (!bus_off && (err_req || ovl_req)) begin
                    state_nx      = S_FLAG;
                    frame_type_nx = !err_req;
                    passive_nx    = err_req ? error_passive : 1'b0;
                    prev_rx_nx    = 1'b0;
                    flag_cnt_nx   = 4'd0;
                    eq_cnt_nx     = 4'd0;
                    dom_cnt_nx    = 4'd0;
                    delim_cnt_nx  = 4'd0;
                    ims_cnt_nx    = 4'd0;
                end
            end
            S_FLAG: begin
                if (bit_tick) begin
                    if (!passive_l) begin
                        flag_cnt_nx = flag_inc;
                        flag_err_nx = can_rx;
                        if (flag_inc >= FLAG_END) begin
                            state_nx   = S_WAIT_REC;
                            dom_cnt_nx = 4'd0;
                        end
                    end else begin
                        eq_cnt_nx  = (eq_cnt == 4'd0 || can_rx != prev_rx) ? 4'd1 : eq_inc;
                        prev_rx_nx = can_rx;
                        if (eq_cnt_nx >= FLAG_END) begin
                            state_nx   = S_WAIT_REC;
                            dom_cnt_nx = 4'd0;
                        end
                    end
                end
            end
            S_WAIT_REC: begin
                if (bit_tick) begin
                    if (can_rx) begin
                        state_nx     = S_DELIM;
                        delim_cnt_nx = 4'd1;
                    end else if (dom_inc == SP_END) begin
                        superpos_nx = 1'b1;
                        dom_cnt_nx  = 4'd0;
                    end else begin
                        dom_cnt_nx = dom_inc;
                    end
                end
            end
            S_DELIM: begin
                if (bit_tick) begin
                    if (can_rx) begin
                        delim_cnt_nx = delim_inc;
                        if (delim_inc >= DELIM_END) begin
                            state_nx   = S_IMS;
                            ims_cnt_nx = 4'd0;
                        end
                    end else begin
                        delim_err_nx  = 1'b1;
                        state_nx      = S_FLAG;
                        frame_type_nx = 1'b0;
                        passive_nx    = error_passive;
                        prev_rx_nx    = 1'b0;
                        flag_cnt_nx   = 4'd0;
                        eq_cnt_nx     = 4'd0;
                        dom_cnt_nx    = 4'd0;
                        delim_cnt_nx  = 4'd0;
                        ims_cnt_nx    = 4'd0;
                    end
                end
            end
            S_IMS: begin
                if (bit_tick) begin
                    ims_cnt_nx = ims_inc;
                    if (ims_inc >= IMS_END) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (state != S_IDLE && bus_off) begin
            state_nx     = S_IDLE;
            done_nx      = 1'b0;
            flag_err_nx  = 1'b0;
            superpos_nx  = 1'b0;
            delim_err_nx = 1'b0;
        end
    end

    // State, counters and registered outputs; outputs follow the next state so they line up with it
    always_ff @(posedge clk_can) begin
        if (rst) begin
            state          <= S_IDLE;
            passive_l      <= 1'b0;
            prev_rx        <= 1'b0;
            flag_cnt       <= 4'd0;
            eq_cnt         <= 4'd0;
            dom_cnt        <= 4'd0;
            delim_cnt      <= 4'd0;
            ims_cnt        <= 4'd0;
            can_tx         <= 1'b1;
            busy           <= 1'b0;
            frame_type     <= 1'b0;
            frame_done     <= 1'b0;
            flag_bit_err   <= 1'b0;
            superpos_err   <= 1'b0;
            delim_form_err <= 1'b0;
        end else begin
            state          <= state_nx;
            passive_l      <= passive_nx;
            prev_rx        <= prev_rx_nx;
            flag_cnt       <= flag_cnt_nx;
            eq_cnt         <= eq_cnt_nx;
            dom_cnt        <= dom_cnt_nx;
            delim_cnt      <= delim_cnt_nx;
            ims_cnt        <= ims_cnt_nx;
            can_tx         <= (state_nx == S_FLAG) ? passive_nx : 1'b1;
            busy           <= (state_nx != S_IDLE);
            frame_type     <= frame_type_nx;
            frame_done     <= done_nx;
            flag_bit_err   <= flag_err_nx;
            superpos_err   <= superpos_nx;
            delim_form_err <= delim_err_nx;
        end
    end

endmodule

// File: tb/tb_can_error_frame_tx.sv
// tb_can_error_frame_tx
// Directed scenarios for the CAN error/overload frame transmitter.
module tb_can_error_frame_tx;

    logic clk_can = 1'b0;
    logic rst, bit_tick, can_rx, err_req, ovl_req, error_passive, bus_off;
    logic can_tx, busy, frame_type, frame_done, flag_bit_err, superpos_err, delim_form_err;
    logic tx_seen;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int fbe_cnt = 0;
    int sp_cnt = 0;
    int dfe_cnt = 0;
    int dom_cyc = 0;

    // 100 MHz block clock
    always #5 clk_can = ~clk_can;

    can_error_frame_tx dut (
        .clk_can        (clk_can),
        .rst            (rst),
        .bit_tick       (bit_tick),
        .can_rx         (can_rx),
        .err_req        (err_req),
        .ovl_req        (ovl_req),
        .error_passive  (error_passive),
        .bus_off        (bus_off),
        .can_tx         (can_tx),
        .busy           (busy),
        .frame_type     (frame_type),
        .frame_done     (frame_done),
        .flag_bit_err   (flag_bit_err),
        .superpos_err   (superpos_err),
        .delim_form_err (delim_form_err)
    );

    // Running tallies of pulses and dominant-drive cycles
    always @(posedge clk_can) begin
        if (frame_done === 1'b1) done_cnt++;
        if (flag_bit_err === 1'b1) fbe_cnt++;
        if (superpos_err === 1'b1) sp_cnt++;
        if (delim_form_err === 1'b1) dfe_cnt++;
        if (can_tx === 1'b0) dom_cyc++;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // One bit time: two idle cycles, then a cycle with bit_tick; returns just after the tick edge
    task automatic send_bit(input logic rx, input logic echo);
        repeat (2) @(negedge clk_can);
        tx_seen  = can_tx;
        can_rx   = echo ? can_tx : rx;
        bit_tick = 1'b1;
        @(negedge clk_can);
        bit_tick = 1'b0;
    endtask

    // One-cycle request pulse
    task automatic request(input logic e, input logic o);
        @(negedge clk_can);
        err_req = e;
        ovl_req = o;
        @(negedge clk_can);
        err_req = 1'b0;
        ovl_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_tick = 1'b0; can_rx = 1'b1; err_req = 1'b0; ovl_req = 1'b0;
        error_passive = 1'b0; bus_off = 1'b0;
        repeat (3) @(negedge clk_can);
        checks++; if (can_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_can_tx: got %b, expected 1", can_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (frame_type !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_type: got %b, expected 0", frame_type); end
        checks++; if ({frame_done, flag_bit_err, superpos_err, delim_form_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses: got %b, expected 0000", {frame_done, flag_bit_err, superpos_err, delim_form_err}); end
        err_req = 1'b1;
        @(negedge clk_can);
        err_req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_blocks_req: got busy %b, expected 0", busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk_can);
        checks++; if (busy !== 1'b0 || can_tx !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle: got busy %b can_tx %b, expected 0 1", busy, can_tx); end
    endtask

    task automatic test_active_error();
        int d0, f0;
        logic exp_tx;
        d0 = done_cnt; f0 = fbe_cnt;
        error_passive = 1'b0;
        request(1'b1, 1'b0);
        checks++; if (busy !== 1'b1 || frame_type !== 1'b0 || can_tx !== 1'b0) begin errors++; $display("[TB] FAIL active_start: got busy %b type %b tx %b, expected 1 0 0", busy, frame_type, can_tx); end
        for (int i = 0; i < 17; i++) begin
            send_bit(1'b1, 1'b1);
            exp_tx = (i < 6) ? 1'b0 : 1'b1;
            checks++; if (tx_seen !== exp_tx) begin errors++; $display("[TB] FAIL active_tx bit %0d: got %b, expected %b", i, tx_seen, exp_tx); end
            if (i < 16) begin
                checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL active_busy bit %0d: got busy %b done %b, expected 1 0", i, busy, frame_done); end
            end else begin
                checks++; if (busy !== 1'b0 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL active_end: got busy %b done %b, expected 0 1", busy, frame_done); end
            end
        end
        repeat (3) @(negedge clk_can);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL active_done_count: got %0d, expected 1", done_cnt - d0); end
        checks++; if (fbe_cnt - f0 != 0) begin errors++; $display("[TB] FAIL active_no_bit_err: got %0d, expected 0", fbe_cnt - f0); end
    endtask

    task automatic test_flag_bit_err();
        int d0, f0;
        d0 = done_cnt; f0 = fbe_cnt;
        request(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            if (i == 2) send_bit(1'b1, 1'b0);
            else send_bit(1'b1, 1'b1);
            if (i == 2) begin
                checks++; if (flag_bit_err !== 1'b1) begin errors++; $display("[TB] FAIL flag_bit_err_pulse: got %b, expected 1", flag_bit_err); end
            end
            if (i == 3) begin
                checks++; if (flag_bit_err !== 1'b0 || tx_seen !== 1'b0) begin errors++; $display("[TB] FAIL flag_continues: got err %b tx %b, expected 0 0", flag_bit_err, tx_seen); end
            end
            if (i == 16) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL flag_err_done: got %b, expected 1", frame_done); end
            end
        end
        repeat (3) @(negedge clk_can);
        checks++; if (fbe_cnt - f0 != 1) begin errors++; $display("[TB] FAIL flag_err_count: got %0d, expected 1", fbe_cnt - f0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL flag_err_done_count: got %0d, expected 1", done_cnt - d0); end
    endtask

    task automatic test_passive();
        int d0, m0;
        d0 = done_cnt; m0 = dom_cyc;
        error_passive = 1'b1;
        request(1'b1, 1'b0);
        checks++; if (busy !== 1'b1 || can_tx !== 1'b1) begin errors++; $display("[TB] FAIL passive_start: got busy %b tx %b, expected 1 1", busy, can_tx); end
        for (int i = 0; i < 8; i++) send_bit((i < 2) ? 1'b1 : 1'b0, 1'b0);
        for (int j = 0; j < 11; j++) begin
            send_bit(1'b1, 1'b0);
            if (j == 9) begin
                checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL passive_busy: got busy %b done %b, expected 1 0", busy, frame_done); end
            end
            if (j == 10) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL passive_done: got %b, expected 1", frame_done); end
            end
        end
        // Five zeros then recessive: the flag must restart its equal-bit count
        request(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit((i < 2) ? 1'b1 : 1'b0, 1'b0);
        for (int j = 0; j < 17; j++) begin
            send_bit(1'b1, 1'b0);
            if (j == 15) begin
                checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL passive_restart_busy: got busy %b done %b, expected 1 0", busy, frame_done); end
            end
            if (j == 16) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL passive_restart_done: got %b, expected 1", frame_done); end
            end
        end
        repeat (3) @(negedge clk_can);
        checks++; if (dom_cyc - m0 != 0) begin errors++; $display("[TB] FAIL passive_never_dominant: got %0d dominant cycles, expected 0", dom_cyc - m0); end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("[TB] FAIL passive_done_count: got %0d, expected 2", done_cnt - d0); end
        error_passive = 1'b0;
    endtask

    task automatic test_superpos();
        int d0, s0;
        d0 = done_cnt; s0 = sp_cnt;
        request(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_bit(1'b0, 1'b0);
            if (i == 0) begin
                checks++; if (can_tx !== 1'b1) begin errors++; $display("[TB] FAIL wait_rec_tx: got %b, expected 1", can_tx); end
            end
            if (i == 6 || i == 8) begin
                checks++; if (superpos_err !== 1'b0) begin errors++; $display("[TB] FAIL superpos_early bit %0d: got %b, expected 0", i, superpos_err); end
            end
            if (i == 7 || i == 15) begin
                checks++; if (superpos_err !== 1'b1) begin errors++; $display("[TB] FAIL superpos_pulse bit %0d: got %b, expected 1", i, superpos_err); end
            end
        end
        for (int j = 0; j < 11; j++) begin
            send_bit(1'b1, 1'b0);
            if (j == 9) begin
                checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL superpos_busy: got busy %b done %b, expected 1 0", busy, frame_done); end
            end
            if (j == 10) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL superpos_done: got %b, expected 1", frame_done); end
            end
        end
        repeat (3) @(negedge clk_can);
        checks++; if (sp_cnt - s0 != 2) begin errors++; $display("[TB] FAIL superpos_count: got %0d, expected 2", sp_cnt - s0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL superpos_done_count: got %0d, expected 1", done_cnt - d0); end
    endtask

    task automatic test_delim_form();
        int d0, e0;
        d0 = done_cnt; e0 = dfe_cnt;
        request(1'b0, 1'b1);
        checks++; if (frame_type !== 1'b1) begin errors++; $display("[TB] FAIL ovl_type: got %b, expected 1", frame_type); end
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++; if (delim_form_err !== 1'b1) begin errors++; $display("[TB] FAIL delim_err_pulse: got %b, expected 1", delim_form_err); end
        checks++; if (can_tx !== 1'b0 || busy !== 1'b1 || frame_type !== 1'b0) begin errors++; $display("[TB] FAIL delim_reflag: got tx %b busy %b type %b, expected 0 1 0", can_tx, busy, frame_type); end
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1, 1'b1);
            checks++; if (tx_seen !== 1'b0) begin errors++; $display("[TB] FAIL reflag_tx bit %0d: got %b, expected 0", i, tx_seen); end
        end
        for (int j = 0; j < 11; j++) begin
            send_bit((j < 8) ? 1'b1 : 1'b0, 1'b0);
            if (j == 10) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL delim_err_done: got %b, expected 1", frame_done); end
            end
        end
        repeat (3) @(negedge clk_can);
        checks++; if (dfe_cnt - e0 != 1) begin errors++; $display("[TB] FAIL delim_err_count: got %0d, expected 1", dfe_cnt - e0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL delim_done_count: got %0d, expected 1", done_cnt - d0); end
    endtask

    task automatic test_bus_off();
        int d0;
        d0 = done_cnt;
        request(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        bus_off = 1'b1;
        @(negedge clk_can);
        checks++; if (busy !== 1'b0 || can_tx !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL bus_off_abort: got busy %b tx %b done %b, expected 0 1 0", busy, can_tx, frame_done); end
        request(1'b1, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bus_off_blocks_req: got %b, expected 0", busy); end
        bus_off = 1'b0;
        repeat (3) @(negedge clk_can);
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL bus_off_no_done: got %0d, expected 0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_flag();
        int d0;
        d0 = done_cnt;
        error_passive = 1'b1;
        request(1'b0, 1'b1);
        checks++; if (frame_type !== 1'b1 || can_tx !== 1'b0) begin errors++; $display("[TB] FAIL ovl_dominant: got type %b tx %b, expected 1 0", frame_type, can_tx); end
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        @(negedge clk_can);
        rst = 1'b1;
        @(negedge clk_can);
        checks++; if (busy !== 1'b0 || can_tx !== 1'b1 || frame_type !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_flag: got busy %b tx %b type %b, expected 0 1 0", busy, can_tx, frame_type); end
        rst = 1'b0;
        error_passive = 1'b0;
        repeat (3) @(negedge clk_can);
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL reset_no_done: got %0d, expected 0", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        logic exp_tx;
        d0 = done_cnt;
        request(1'b1, 1'b1);
        checks++; if (frame_type !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL both_req_type: got type %b busy %b, expected 0 1", frame_type, busy); end
        for (int i = 0; i < 17; i++) begin
            send_bit(1'b1, 1'b1);
            exp_tx = (i < 6) ? 1'b0 : 1'b1;
            checks++; if (tx_seen !== exp_tx) begin errors++; $display("[TB] FAIL both_tx bit %0d: got %b, expected %b", i, tx_seen, exp_tx); end
            if (i == 2) begin
                request(1'b0, 1'b1);
                request(1'b1, 1'b0);
                checks++; if (frame_type !== 1'b0) begin errors++; $display("[TB] FAIL busy_req_ignored: got type %b, expected 0", frame_type); end
            end
            if (i == 16) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL both_done: got %b, expected 1", frame_done); end
            end
        end
        repeat (3) @(negedge clk_can);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL both_done_count: got %0d, expected 1", done_cnt - d0); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_active_error();
        test_flag_bit_err();
        test_passive();
        test_superpos();
        test_delim_form();
        test_bus_off();
        test_reset_mid_flag();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
